// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit saturating-counter branch predictor.
// Resolves BEQ/BNE from the ALU zero flag to drive the PC-source select.
// A direct-mapped table of ENTRIES counters, indexed by word-aligned PC,
// gives a zero-latency taken/not-taken prediction for the fetch stage and
// flags mispredicts at resolution.
//
// Optional feature (macro BP_STATS_EN): adds the 32-bit saturating statistics
// registers stat_branches_o and stat_mispredicts_o.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   if_pc_i             fetch PC for lookup       -> pred_taken_o
//   upd_valid_i         resolving instruction valid this cycle
//   upd_pc_i            PC of resolving instruction
//   branch_i            resolving instruction is a branch
//   branch_type_i       0 = BEQ, 1 = BNE
//   aluzero_i           ALU zero flag
//   select_o            actual taken (PC-source mux select)
//   mispredict_o        resolved outcome differs from table prediction
//   stat_branches_o     (BP_STATS_EN) count of resolved branches
//   stat_mispredicts_o  (BP_STATS_EN) count of mispredicted branches
module branch_predict_unit #(
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned ENTRIES  = 16,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PC_WIDTH-1:0] if_pc_i,
   output logic                pred_taken_o,
   input  logic                upd_valid_i,
   input  logic [PC_WIDTH-1:0] upd_pc_i,
   input  logic                branch_i,
   input  logic                branch_type_i,
   input  logic                aluzero_i,
   output logic                select_o,
`ifdef BP_STATS_EN
   output logic [31:0]         stat_branches_o,
   output logic [31:0]         stat_mispredicts_o,
`endif
   output logic                mispredict_o
);

   localparam int unsigned STAT_W = 32;

   logic [1:0]       ctr_q [ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_en;
   logic             upd_pred;
   logic             pc_unused;

   // Word-aligned index; low two bits and upper bits do not select a counter.
   assign if_idx  = if_pc_i[IDX_W+1:2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign pc_unused = ^{if_pc_i[PC_WIDTH-1:IDX_W+2], if_pc_i[1:0],
                        upd_pc_i[PC_WIDTH-1:IDX_W+2], upd_pc_i[1:0]};

   // Prediction and resolution, all combinational on pre-edge table state.
   always_comb begin
      upd_en       = upd_valid_i & branch_i;
      pred_taken_o = ctr_q[if_idx][1];
      upd_pred     = ctr_q[upd_idx][1];
      select_o     = upd_en & (branch_type_i ? ~aluzero_i : aluzero_i);
      mispredict_o = upd_en & (select_o != upd_pred);
   end

   // Counter table: reset to weak-NT, saturating update on resolved branches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (upd_en) begin
         if (select_o) begin
            if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
         end else begin
            if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
         end
      end
   end

`ifdef BP_STATS_EN
   // Saturating branch / mispredict statistics.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_branches_o    <= '0;
         stat_mispredicts_o <= '0;
      end else if (upd_en) begin
         if (stat_branches_o != '1)
            stat_branches_o <= stat_branches_o + STAT_W'(1);
         if (mispredict_o && (stat_mispredicts_o != '1))
            stat_mispredicts_o <= stat_mispredicts_o + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed test-plan sequences
// plus randomized traffic checked against a behavioural counter-table model.
module tb_branch_predict_unit;

   localparam int unsigned PC_WIDTH = 32;
   localparam int unsigned ENTRIES  = 16;

   logic                clk;
   logic                rst;
   logic [PC_WIDTH-1:0] if_pc;
   logic                pred_taken;
   logic                upd_valid;
   logic [PC_WIDTH-1:0] upd_pc;
   logic                branch;
   logic                branch_type;
   logic                aluzero;
   logic                select;
   logic                mispredict;
`ifdef BP_STATS_EN
   logic [31:0]         stat_branches;
   logic [31:0]         stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: one integer strength 0..3 per table slot.
   int          model [ENTRIES];
   longint      exp_br = 0;
   longint      exp_mp = 0;

   branch_predict_unit #(.PC_WIDTH(PC_WIDTH), .ENTRIES(ENTRIES)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .if_pc_i       (if_pc),
      .pred_taken_o  (pred_taken),
      .upd_valid_i   (upd_valid),
      .upd_pc_i      (upd_pc),
      .branch_i      (branch),
      .branch_type_i (branch_type),
      .aluzero_i     (aluzero),
      .select_o      (select),
`ifdef BP_STATS_EN
      .stat_branches_o    (stat_branches),
      .stat_mispredicts_o (stat_mispredicts),
`endif
      .mispredict_o  (mispredict)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic logic predicts_taken(input logic [31:0] pc);
      return model[slot(pc)] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) model[i] = 1;
      exp_br = 0;
      exp_mp = 0;
   endtask

   // One cycle: drive inputs just after an edge, check mid-cycle, then
   // advance through the next edge and update the model.
   task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] upc,
                        input logic br, input logic bt, input logic z);
      logic taken;
      logic exp_mis;
      if_pc = ipc; upd_valid = v; upd_pc = upc;
      branch = br; branch_type = bt; aluzero = z;
      #20;
      taken   = v && br && (bt ? !z : z);
      exp_mis = v && br && (taken != predicts_taken(upc));
      check("pred_taken", 32'(pred_taken), 32'(predicts_taken(ipc)));
      check("select", 32'(select), 32'(taken));
      check("mispredict", 32'(mispredict), 32'(exp_mis));
      @(posedge clk);
      if (v && br) begin
         if (taken) model[slot(upc)] = (model[slot(upc)] == 3) ? 3 : model[slot(upc)] + 1;
         else       model[slot(upc)] = (model[slot(upc)] == 0) ? 0 : model[slot(upc)] - 1;
         if (exp_br != 64'hFFFF_FFFF) exp_br++;
         if (exp_mis && exp_mp != 64'hFFFF_FFFF) exp_mp++;
      end
      #1;
   endtask

   task automatic idle_lookup(input logic [31:0] ipc);
      drive(ipc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
      branch = 1'b0; branch_type = 1'b0; aluzero = 1'b0;
      model_reset();
      #20;
      check("rst_pred", 32'(pred_taken), 32'd0);
      check("rst_select", 32'(select), 32'd0);
      check("rst_mispredict", 32'(mispredict), 32'd0);
`ifdef BP_STATS_EN
      check("rst_stat_br", stat_branches, 32'd0);
      check("rst_stat_mp", stat_mispredicts, 32'd0);
`endif
      @(posedge clk); #10;
      rst = 1'b0;
      @(posedge clk); #1;

      // Sweep every slot after reset: all weak-NT.
      for (int i = 0; i < ENTRIES; i++) idle_lookup(32'(i * 4));

      // Three taken BEQs at 0x40, then two not-taken.
      for (int i = 0; i < 3; i++) drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
      idle_lookup(32'h40);
      for (int i = 0; i < 2; i++) drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      idle_lookup(32'h40);

      // BNE outcomes and a non-branch with zero set.
      drive(32'h44, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
      drive(32'h44, 1'b1, 32'h48, 1'b1, 1'b1, 1'b1);
      drive(32'h48, 1'b1, 32'h48, 1'b0, 1'b0, 1'b1);
      idle_lookup(32'h48);

      // Same-cycle lookup/update at 0x80, then alias check.
      drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1);
      idle_lookup(32'h80);
      idle_lookup(32'h80 + 32'(4 * ENTRIES));

      // Async reset between edges with an update pending in the reset cycle.
      drive(32'h44, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
      drive(32'h44, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
      upd_valid = 1'b1; upd_pc = 32'h44; branch = 1'b1; branch_type = 1'b0; aluzero = 1'b1;
      #5;
      rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < ENTRIES; i++) begin
         if_pc = 32'(i * 4);
         #1;
         check("async_rst_pred", 32'(pred_taken), 32'd0);
      end
      @(posedge clk); #10;
      rst = 1'b0;
      upd_valid = 1'b0;
      @(posedge clk); #1;
      idle_lookup(32'h44);

`ifdef BP_STATS_EN
      // 5 branches, exactly 2 mispredicts (fresh table, all weak-NT).
      drive(32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
      drive(32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
      drive(32'h0, 1'b1, 32'h108, 1'b1, 1'b1, 1'b1);
      drive(32'h0, 1'b1, 32'h10C, 1'b1, 1'b1, 1'b0);
      drive(32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
      check("stat_branches_5", stat_branches, 32'd5);
      check("stat_mispredicts_2", stat_mispredicts, 32'd2);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive(32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0),
               32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom));
      end

`ifdef BP_STATS_EN
      check("stat_branches_end", stat_branches, 32'(exp_br));
      check("stat_mispredicts_end", stat_mispredicts, 32'(exp_mp));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor of the branch/zero select gate for the pipelined datapath.
- Resolves branch outcome (BEQ/BNE) from the ALU zero flag and drives the PC-source select.
- Adds a direct-mapped table of 2-bit saturating counters, indexed by PC, for IF-stage taken/not-taken prediction.
- Flags mispredicts at resolution; sits between the EX stage and the PC mux / flush logic.

Parameters:
- PC_WIDTH, 32, width of program counter inputs.
- ENTRIES, 16, number of predictor counters; power of two, 2..256.
- IDX_W, log2(ENTRIES), index width; derived, never overridden.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- if_pc_i  input  PC_WIDTH  fetch-stage PC for lookup.
- pred_taken_o  output  1  prediction for if_pc_i.
- upd_valid_i  input  1  EX-stage instruction is resolved this cycle.
- upd_pc_i  input  PC_WIDTH  PC of the resolving instruction.
- branch_i  input  1  resolving instruction is a branch.
- branch_type_i  input  1  0 = BEQ, 1 = BNE.
- aluzero_i  input  1  ALU zero flag of the resolving instruction.
- select_o  output  1  actual taken; drives PC-source mux.
- mispredict_o  output  1  resolved outcome differs from table prediction.

Behaviour:
- Index = pc[IDX_W+1:2]; bits [1:0] ignored (word-aligned PCs).
- Table holds ENTRIES × 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst_i=1): all counters forced to 01. Outputs then follow the combinational rules below with table = 01, so pred_taken_o = 0, select_o = 0, mispredict_o = 0.
- pred_taken_o:
  - Combinational, counter[idx(if_pc_i)][1].
  - Zero latency.
- select_o:
  - Combinational, upd_valid_i & branch_i & (branch_type_i ? ~aluzero_i : aluzero_i).
  - With branch_type_i = 0 this equals branch & zero.
- mispredict_o:
  - Combinational, upd_valid_i & branch_i & (select_o != counter[idx(upd_pc_i)][1]).
  - Non-branch or invalid cycles give 0.
- Counter update:
  - Occurs at the rising clk_i edge when upd_valid_i & branch_i.
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - No other entry changes. No update when branch_i = 0 or upd_valid_i = 0.
- Same-index lookup and update in one cycle: pred_taken_o and mispredict_o use the pre-edge value (no bypass). The new value is visible the cycle after the edge.
- PC aliasing: different PCs with the same index share a counter, by design.
- Reset asserted mid-operation: table is reinitialised immediately, regardless of clock. Any in-flight update in that cycle is discarded.
- X on inputs while upd_valid_i = 0 does not affect table state.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches_o [31:0] and stat_mispredicts_o [31:0].
  - Both are registers, reset to 0.
  - stat_branches_o increments on each updating edge.
  - stat_mispredicts_o increments on each updating edge where mispredict_o = 1.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then sweep if_pc_i across all ENTRIES word addresses -> pred_taken_o = 0 everywhere. A BEQ at 0x40 with zero = 1 -> select_o = 1, mispredict_o = 1.
- Three taken BEQ updates at pc 0x40 -> counter 01→10→11→11. pred_taken_o at 0x40 becomes 1 after the first edge. Then two not-taken updates -> 10, 01; prediction returns to 0 after the second.
- BNE with aluzero_i = 0 -> select_o = 1. BNE with aluzero_i = 1 -> select_o = 0. branch_i = 0 with aluzero_i = 1 -> select_o = 0, mispredict_o = 0, table unchanged.
- Same-cycle lookup and update at 0x80 (counter 01, taken) -> pred_taken_o = 0 that cycle, 1 the next. Aliasing check: 0x80 and 0x80 + 4·ENTRIES return the same prediction.
- Drive taken updates, assert rst_i between clock edges -> all counters read 01 immediately, without waiting for a clock edge. An update in the reset cycle has no effect.
- BP_STATS_EN: 5 branches with 2 mispredicts -> stat_branches_o = 5, stat_mispredicts_o = 2. Preload near saturation -> values hold at FFFF_FFFF.
